// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: pixel/line counters, sync pulses, data enable
// and line/frame strobes, all registered and aligned to the current (hc,vc) position.
module vga_timing_gen #(
  parameter int CW       = 10,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 24,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 128,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 9,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 28,
  parameter int H_POL    = 0,
  parameter int V_POL    = 0
) (
  input  logic          px_clk,
  input  logic          reset_n,
  input  logic          en,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [CW-1:0] x_px,
  output logic [CW-1:0] y_px,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > (2 ** CW) || V_TOTAL > (2 ** CW)) begin : g_bad_cw
    $error("vga_timing_gen: CW too small for H_TOTAL/V_TOTAL");
  end

  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 || CW < 1) begin : g_bad_param
    $error("vga_timing_gen: every timing parameter must be >= 1");
  end

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic          HP       = (H_POL != 0);
  localparam logic          VP       = (V_POL != 0);

  logic [CW-1:0] hc, vc;
  logic [CW-1:0] hc_nxt, vc_nxt;
  logic          hsync_nxt, vsync_nxt, de_nxt;

  // Outputs are derived from the position being stepped into, so the registered
  // outputs always describe the registered counters with no pipeline skew.
  always_comb begin
    hc_nxt = hc + CW'(1);
    vc_nxt = vc;
    if (hc >= H_LAST) begin
      hc_nxt = '0;
      vc_nxt = (vc >= V_LAST) ? '0 : vc + CW'(1);
    end
    hsync_nxt = (hc_nxt >= HS_START && hc_nxt < HS_END) ? HP : ~HP;
    vsync_nxt = (vc_nxt >= VS_START && vc_nxt < VS_END) ? VP : ~VP;
    de_nxt    = (hc_nxt < H_ACT) && (vc_nxt < V_ACT);
  end

  // Reset parks the counters on the last pixel of the frame so the first
  // enabled step lands on (0,0) and raises both strobes.
  always_ff @(posedge px_clk) begin
    if (!reset_n) begin
      hc          <= H_LAST;
      vc          <= V_LAST;
      hsync       <= ~HP;
      vsync       <= ~VP;
      de          <= 1'b0;
      x_px        <= '0;
      y_px        <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (en) begin
      hc          <= hc_nxt;
      vc          <= vc_nxt;
      hsync       <= hsync_nxt;
      vsync       <= vsync_nxt;
      de          <= de_nxt;
      x_px        <= hc_nxt;
      y_px        <= vc_nxt;
      line_start  <= (hc_nxt == '0);
      frame_start <= (hc_nxt == '0) && (vc_nxt == '0);
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: three parameter sets share one stimulus stream,
// each checked every cycle against a linear-pixel-index reference model.
module tb_vga_timing_gen;

  // Medium raster small enough to cover whole frames and vsync quickly.
  localparam int B_CW = 7;
  localparam int B_HA = 20, B_HF = 3, B_HS = 5, B_HB = 4;
  localparam int B_VA = 12, B_VF = 2, B_VS = 3, B_VB = 2;
  localparam int B_HP = 1, B_VP = 0;

  localparam int C_CW = 4;
  localparam int C_HA = 4, C_HF = 1, C_HS = 2, C_HB = 1;
  localparam int C_VA = 3, C_VF = 1, C_VS = 1, C_VB = 1;
  localparam int C_HP = 1, C_VP = 1;

  typedef struct packed {
    logic        hsync;
    logic        vsync;
    logic        de;
    logic [15:0] x;
    logic [15:0] y;
    logic        ls;
    logic        fs;
  } exp_t;

  typedef struct packed {
    exp_t a;
    exp_t b;
    exp_t c;
  } bundle_t;

  logic px_clk;
  logic reset_n;
  logic en;

  logic hsync_a, vsync_a, de_a, ls_a, fs_a;
  logic [9:0] x_a, y_a;
  logic hsync_b, vsync_b, de_b, ls_b, fs_b;
  logic [B_CW-1:0] x_b, y_b;
  logic hsync_c, vsync_c, de_c, ls_c, fs_c;
  logic [C_CW-1:0] x_c, y_c;

  bundle_t sb[$];
  bundle_t mon_exp;
  int      checks;
  int      fails;
  int      pos_a, pos_b, pos_c;
  exp_t    out_a, out_b, out_c;

  vga_timing_gen dut_a (
    .px_clk(px_clk), .reset_n(reset_n), .en(en),
    .hsync(hsync_a), .vsync(vsync_a), .de(de_a),
    .x_px(x_a), .y_px(y_a), .line_start(ls_a), .frame_start(fs_a)
  );

  vga_timing_gen #(
    .CW(B_CW), .H_ACTIVE(B_HA), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
    .V_ACTIVE(B_VA), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB),
    .H_POL(B_HP), .V_POL(B_VP)
  ) dut_b (
    .px_clk(px_clk), .reset_n(reset_n), .en(en),
    .hsync(hsync_b), .vsync(vsync_b), .de(de_b),
    .x_px(x_b), .y_px(y_b), .line_start(ls_b), .frame_start(fs_b)
  );

  vga_timing_gen #(
    .CW(C_CW), .H_ACTIVE(C_HA), .H_FP(C_HF), .H_SYNC(C_HS), .H_BP(C_HB),
    .V_ACTIVE(C_VA), .V_FP(C_VF), .V_SYNC(C_VS), .V_BP(C_VB),
    .H_POL(C_HP), .V_POL(C_VP)
  ) dut_c (
    .px_clk(px_clk), .reset_n(reset_n), .en(en),
    .hsync(hsync_c), .vsync(vsync_c), .de(de_c),
    .x_px(x_c), .y_px(y_c), .line_start(ls_c), .frame_start(fs_c)
  );

  initial px_clk = 1'b0;
  always #5 px_clk = ~px_clk;

  // Position is one linear pixel index p over the whole frame; (hc,vc) fall out by div/mod.
  task automatic model_step(input int ha, hf, hs, hb, va, vf, vs, vb,
                            input bit hp, vp, input bit rst_v, en_v,
                            inout int p, inout exp_t o);
    int ht;
    int total;
    int hc;
    int vc;
    ht    = ha + hf + hs + hb;
    total = ht * (va + vf + vs + vb);
    if (!rst_v) begin
      p       = total - 1;
      o.hsync = ~hp;
      o.vsync = ~vp;
      o.de    = 1'b0;
      o.x     = 16'd0;
      o.y     = 16'd0;
      o.ls    = 1'b0;
      o.fs    = 1'b0;
    end else if (en_v) begin
      p       = (p + 1) % total;
      hc      = p % ht;
      vc      = p / ht;
      o.x     = 16'(hc);
      o.y     = 16'(vc);
      o.de    = (hc < ha) && (vc < va);
      o.hsync = (hc >= ha + hf && hc < ha + hf + hs) ? hp : ~hp;
      o.vsync = (vc >= va + vf && vc < va + vf + vs) ? vp : ~vp;
      o.ls    = (hc == 0);
      o.fs    = (p == 0);
    end else begin
      o.ls = 1'b0;
      o.fs = 1'b0;
    end
  endtask

  task automatic apply_stimulus(input bit rst_v, input bit en_v);
    bundle_t b;
    reset_n = rst_v;
    en      = en_v;
    model_step(640, 24, 40, 128, 480, 9, 3, 28, 1'b0, 1'b0, rst_v, en_v, pos_a, out_a);
    model_step(B_HA, B_HF, B_HS, B_HB, B_VA, B_VF, B_VS, B_VB,
               B_HP[0], B_VP[0], rst_v, en_v, pos_b, out_b);
    model_step(C_HA, C_HF, C_HS, C_HB, C_VA, C_VF, C_VS, C_VB,
               C_HP[0], C_VP[0], rst_v, en_v, pos_c, out_c);
    b.a = out_a;
    b.b = out_b;
    b.c = out_c;
    sb.push_back(b);
    @(posedge px_clk);
    #1;
  endtask

  task automatic check_output(input string name, input exp_t act, input exp_t exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s @%0t: actual hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b, expected hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b",
               name, $time, act.hsync, act.vsync, act.de, act.x, act.y, act.ls, act.fs,
               exp.hsync, exp.vsync, exp.de, exp.x, exp.y, exp.ls, exp.fs);
    end
  endtask

  // Monitor: samples on the falling edge, away from the edge that updates the DUT.
  initial begin
    forever begin
      @(negedge px_clk);
      if (sb.size() > 0) begin
        mon_exp = sb.pop_front();
        check_output("dut_a", {hsync_a, vsync_a, de_a, 16'(x_a), 16'(y_a), ls_a, fs_a}, mon_exp.a);
        check_output("dut_b", {hsync_b, vsync_b, de_b, 16'(x_b), 16'(y_b), ls_b, fs_b}, mon_exp.b);
        check_output("dut_c", {hsync_c, vsync_c, de_c, 16'(x_c), 16'(y_c), ls_c, fs_c}, mon_exp.c);
      end
    end
  end

  initial begin
    checks = 0;
    fails  = 0;
    pos_a  = 0;
    pos_b  = 0;
    pos_c  = 0;
    out_a  = '0;
    out_b  = '0;
    out_c  = '0;
    reset_n = 1'b0;
    en      = 1'b1;

    $display("[TB] reset with en held high");
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b1);

    // Default raster runs past the (831,10) -> (0,11) wrap; small rasters wrap many frames.
    $display("[TB] free-running with en=1");
    for (int i = 0; i < 12000; i++) apply_stimulus(1'b1, 1'b1);

    $display("[TB] en toggling");
    for (int i = 0; i < 200; i++) apply_stimulus(1'b1, i[0] == 1'b0);

    $display("[TB] mid-frame reset pulse");
    apply_stimulus(1'b0, 1'b1);
    for (int i = 0; i < 700; i++) apply_stimulus(1'b1, 1'b1);
    apply_stimulus(1'b0, 1'b0);
    apply_stimulus(1'b1, 1'b0);
    apply_stimulus(1'b1, 1'b1);

    $display("[TB] randomized en / reset_n");
    for (int i = 0; i < 20000; i++)
      apply_stimulus($urandom_range(0, 1499) != 0, $urandom_range(0, 3) != 0);

    for (int k = 0; k < 10 && sb.size() > 0; k++) begin
      @(negedge px_clk);
      #1;
    end
    checks++;
    if (sb.size() != 0) begin
      fails++;
      $display("[TB] FAIL drain: actual %0d entries left, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
